// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle unsigned RV32M multiply/divide sequencer.
// It borrows an external ALU for one add or subtract per cycle. Multiply uses
// shift-add over a 64-bit product register. Divide uses restoring division
// with a remainder/quotient pair. Both run for 32 iterations.
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  state_t state, state_next;

  logic [1:0]         op_q;
  logic [4:0]         cnt;
  logic [2*WIDTH-1:0] p;
  logic [WIDTH-1:0]   m;
  logic [WIDTH-1:0]   r;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   d;

  logic               is_div_q;
  logic               launch;
  logic               div_by_zero;
  logic               last_step;

  logic [WIDTH-1:0]   p_hi;
  logic               mul_carry;
  logic [2*WIDTH-1:0] p_step;
  logic [WIDTH-1:0]   div_t;
  logic               div_ge;
  logic [WIDTH-1:0]   r_step;
  logic [WIDTH-1:0]   q_step;
  logic [WIDTH-1:0]   final_result;

  assign is_div_q    = op_q[1];
  assign launch      = (state == IDLE) && start;
  assign div_by_zero = op[1] && (rs2 == '0);
  assign last_step   = (state == RUN) && (cnt == 5'd31);
  assign p_hi        = p[2*WIDTH-1:WIDTH];

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // State register; reset aborts any operation back to IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: divide by zero skips RUN entirely
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = div_by_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt == 5'd31) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ALU drive: divide subtracts the shifted remainder, multiply adds M to the high half
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = ALU_ADD;
    if (state == RUN) begin
      if (is_div_q) begin
        alu_a    = div_t;
        alu_b    = d;
        alu_ctrl = ALU_SUB;
      end else begin
        alu_a    = p_hi;
        alu_b    = m;
        alu_ctrl = ALU_ADD;
      end
    end
  end

  // One iteration of each algorithm, computed from the current registers and the ALU result
  always_comb begin
    div_t     = {r[WIDTH-2:0], q[WIDTH-1]};
    div_ge    = r[WIDTH-1] | alu_cout;
    r_step    = div_ge ? alu_out : div_t;
    q_step    = {q[WIDTH-2:0], div_ge};
    mul_carry = (alu_out < p_hi);
    if (p[0]) begin
      p_step = {mul_carry, alu_out, p[WIDTH-1:1]};
    end else begin
      p_step = {1'b0, p[2*WIDTH-1:1]};
    end
    final_result = '0;
    unique case (op_q)
      OP_MUL:   final_result = p_step[WIDTH-1:0];
      OP_MULHU: final_result = p_step[2*WIDTH-1:WIDTH];
      OP_DIVU:  final_result = q_step;
      OP_REMU:  final_result = r_step;
      default:  final_result = '0;
    endcase
  end

  // Datapath registers: load on launch, iterate in RUN, capture the result on the last step
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= 2'b00;
      cnt    <= 5'd0;
      p      <= '0;
      m      <= '0;
      r      <= '0;
      q      <= '0;
      d      <= '0;
      result <= '0;
    end else begin
      if (launch) begin
        op_q <= op;
        cnt  <= 5'd0;
        if (op[1]) begin
          r <= '0;
          q <= rs1;
          d <= rs2;
          if (div_by_zero) begin
            result <= op[0] ? rs1 : {WIDTH{1'b1}};
          end
        end else begin
          p <= {{WIDTH{1'b0}}, rs2};
          m <= rs1;
        end
      end else if (state == RUN) begin
        cnt <= cnt + 5'd1;
        if (is_div_q) begin
          r <= r_step;
          q <= q_step;
        end else begin
          p <= p_step;
        end
        if (last_step) begin
          result <= final_result;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed self-checking bench for mdu_seq with a behavioural ALU.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_out;
  logic        alu_cout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .rs1      (rs1),
    .rs2      (rs2),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_ctrl (alu_ctrl),
    .alu_out  (alu_out),
    .alu_cout (alu_cout)
  );

  // Reference ALU: add or subtract, carry reports unsigned a >= b on subtract
  always_comb begin
    alu_out  = 32'd0;
    alu_cout = 1'b0;
    if (alu_ctrl == 4'b0001) begin
      alu_out  = alu_a - alu_b;
      alu_cout = (alu_a >= alu_b);
    end else begin
      {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
    end
  end

  // Launches one op at edge 0 and observes cycles 1..36; scrambles operands after launch
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                               output int done_cyc, output int done_cnt, output int busy_cnt,
                               output logic [31:0] res, output int alu_bad);
    done_cyc = 0;
    done_cnt = 0;
    busy_cnt = 0;
    res      = 32'd0;
    alu_bad  = 0;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    rs1   = a;
    rs2   = b;
    for (int cyc = 1; cyc <= 36; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start = 1'b0;
        rs1   = ~a;
        rs2   = b + 32'd3;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
        res = result;
      end
      if ((!busy || done) && (alu_a != 32'd0 || alu_b != 32'd0 || alu_ctrl != 4'd0)) alu_bad++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    rs1   = 32'd0;
    rs2   = 32'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got busy=%b done=%b expected 0 0", busy, done);
    end
    checks++;
    if (result !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_result: got %h expected 00000000", result);
    end
    checks++;
    if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctrl !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_alu: got a=%h b=%h ctrl=%h expected zeros", alu_a, alu_b, alu_ctrl);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [1:0]  vo[4] = '{2'b00, 2'b01, 2'b01, 2'b00};
    logic [31:0] va[4] = '{32'd7, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] vb[4] = '{32'd6, 32'd6, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ve[4] = '{32'd42, 32'd0, 32'hFFFFFFFE, 32'h00000001};
    int dc, dn, bc, ab;
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vo[i], va[i], vb[i], dc, dn, bc, res, ab);
      checks++;
      if (res !== ve[i]) begin
        errors++;
        $display("[TB] FAIL mul_result[%0d]: got %h expected %h", i, res, ve[i]);
      end
      checks++;
      if (dc != 33 || dn != 1 || bc != 33) begin
        errors++;
        $display("[TB] FAIL mul_timing[%0d]: got done_cyc=%0d dones=%0d busy=%0d expected 33 1 33", i, dc, dn, bc);
      end
    end
  endtask

  task automatic test_div();
    logic [1:0]  vo[6] = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b11};
    logic [31:0] va[6] = '{32'd100, 32'd100, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] vb[6] = '{32'd7, 32'd7, 32'd3, 32'd3, 32'd1, 32'd1};
    logic [31:0] ve[6] = '{32'd14, 32'd2, 32'h2AAAAAAA, 32'd2, 32'hFFFFFFFF, 32'd0};
    int dc, dn, bc, ab;
    logic [31:0] res;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vo[i], va[i], vb[i], dc, dn, bc, res, ab);
      checks++;
      if (res !== ve[i]) begin
        errors++;
        $display("[TB] FAIL div_result[%0d]: got %h expected %h", i, res, ve[i]);
      end
      checks++;
      if (dc != 33 || dn != 1 || bc != 33) begin
        errors++;
        $display("[TB] FAIL div_timing[%0d]: got done_cyc=%0d dones=%0d busy=%0d expected 33 1 33", i, dc, dn, bc);
      end
    end
  endtask

  task automatic test_div_by_zero();
    logic [1:0]  vo[2] = '{2'b10, 2'b11};
    logic [31:0] ve[2] = '{32'hFFFFFFFF, 32'd5};
    int dc, dn, bc, ab;
    logic [31:0] res;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(vo[i], 32'd5, 32'd0, dc, dn, bc, res, ab);
      checks++;
      if (res !== ve[i]) begin
        errors++;
        $display("[TB] FAIL divzero_result[%0d]: got %h expected %h", i, res, ve[i]);
      end
      checks++;
      if (dc != 1 || dn != 1 || bc != 1) begin
        errors++;
        $display("[TB] FAIL divzero_timing[%0d]: got done_cyc=%0d dones=%0d busy=%0d expected 1 1 1", i, dc, dn, bc);
      end
      checks++;
      if (ab != 0) begin
        errors++;
        $display("[TB] FAIL divzero_alu[%0d]: got %0d nonzero cycles expected 0", i, ab);
      end
    end
  endtask

  task automatic test_ignored_start();
    int dn = 0;
    int dc = 0;
    logic [31:0] res = 32'd0;
    logic busy34 = 1'b1;
    int late_busy = 0;
    @(negedge clk);
    start = 1'b1;
    op    = 2'b00;
    rs1   = 32'd3;
    rs2   = 32'd4;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      start = (cyc == 5 || cyc == 33);
      rs1   = 32'd100 + cyc;
      rs2   = 32'd200 + cyc;
      op    = (cyc == 5) ? 2'b10 : 2'b01;
      if (done) begin
        dn++;
        if (dc == 0) dc = cyc;
        res = result;
      end
      if (cyc == 34) busy34 = busy;
      if (cyc > 34 && busy) late_busy++;
    end
    start = 1'b0;
    checks++;
    if (dn != 1 || dc != 33) begin
      errors++;
      $display("[TB] FAIL ignored_done: got dones=%0d done_cyc=%0d expected 1 33", dn, dc);
    end
    checks++;
    if (res !== 32'd12) begin
      errors++;
      $display("[TB] FAIL ignored_result: got %h expected 0000000c", res);
    end
    checks++;
    if (busy34 !== 1'b0 || late_busy != 0) begin
      errors++;
      $display("[TB] FAIL ignored_idle: got busy34=%b late_busy=%0d expected 0 0", busy34, late_busy);
    end
  endtask

  task automatic test_back_to_back();
    int dc = 0;
    logic [31:0] res = 32'd0;
    logic busy35 = 1'b0;
    @(negedge clk);
    start = 1'b1;
    op    = 2'b00;
    rs1   = 32'd3;
    rs2   = 32'd5;
    for (int cyc = 1; cyc <= 70; cyc++) begin
      @(negedge clk);
      start = (cyc == 34);
      if (cyc == 34) begin
        op  = 2'b10;
        rs1 = 32'd20;
        rs2 = 32'd4;
      end
      if (cyc == 35) busy35 = busy;
      if (cyc > 34 && done && dc == 0) begin
        dc  = cyc;
        res = result;
      end
    end
    start = 1'b0;
    checks++;
    if (busy35 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_accept: got busy=%b expected 1", busy35);
    end
    checks++;
    if (dc != 67 || res !== 32'd5) begin
      errors++;
      $display("[TB] FAIL b2b_second: got done_cyc=%0d result=%h expected 67 00000005", dc, res);
    end
  endtask

  task automatic test_reset_mid_op();
    int dc, dn, bc, ab;
    logic [31:0] res;
    @(negedge clk);
    start = 1'b1;
    op    = 2'b10;
    rs1   = 32'd100;
    rs2   = 32'd7;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 10) reset = 1'b1;
      if (cyc == 11) begin
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
          errors++;
          $display("[TB] FAIL midreset_state: got busy=%b done=%b result=%h expected 0 0 00000000", busy, done, result);
        end
      end
    end
    applyStimulus(2'b10, 32'd9, 32'd2, dc, dn, bc, res, ab);
    checks++;
    if (res !== 32'd4 || dc != 33) begin
      errors++;
      $display("[TB] FAIL midreset_next: got result=%h done_cyc=%0d expected 00000004 33", res, dc);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_by_zero();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
